// File: rtl/matrix_display_pkg.sv
// Shared types and constants for the dot-matrix column scanner.
// Holds the glyph table, the per-column record and an index-width helper.
// The glyph table fixes the default code width (3) and row count (7).
package matrix_display_pkg;

  localparam int PKG_COLUMN_SIZE = 7;
  localparam int PKG_CODE_WIDTH  = 3;
  localparam int PKG_ENTRIES     = 2 ** PKG_CODE_WIDTH;

  // Row patterns indexed by symbol code; bit 0 is the top row.
  localparam logic [PKG_COLUMN_SIZE-1:0] PATTERN [PKG_ENTRIES] = '{
    7'h00, 7'h7F, 7'h41, 7'h2A, 7'h1C, 7'h55, 7'h63, 7'h08
  };

  // One stored column: which symbol, whether it is lit, whether it blinks.
  typedef struct packed {
    logic [PKG_CODE_WIDTH-1:0] code;
    logic                      enable;
    logic                      blink;
  } column_t;

  // Width of a counter/index addressing n items; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/column_pattern_rom.sv
// Combinational symbol-code to row-pattern lookup.
// Latency: zero cycles (pure logic).
// Backpressure: none; output follows code immediately.
module column_pattern_rom
  import matrix_display_pkg::*;
#(
  parameter int COLUMN_SIZE = PKG_COLUMN_SIZE,
  parameter int CODE_WIDTH  = PKG_CODE_WIDTH
) (
  input  logic [CODE_WIDTH-1:0]  code,
  output logic [COLUMN_SIZE-1:0] pattern
);

  // Table lookup of the glyph for the requested code.
  always_comb begin
    pattern = PATTERN[code];
  end

endmodule

// File: rtl/matrix_display_scanner.sv
// Time-multiplexed dot-matrix driver: per-column symbol store, column scan with blanking, blink.
// Latency: all outputs registered; a write to the shown column appears the cycle after acceptance.
// Backpressure: load_ready is low only during reset and the cycle it is released; one write per cycle otherwise.
module matrix_display_scanner
  import matrix_display_pkg::*;
#(
  parameter  int COLUMN_SIZE   = 7,
  parameter  int TOTAL_COLUMNS = 5,
  parameter  int CODE_WIDTH    = 3,
  parameter  int SCAN_DIV      = 50000,
  parameter  int BLINK_FRAMES  = 32,
  localparam int IDX_W         = idx_w(TOTAL_COLUMNS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [IDX_W-1:0]         load_index,
  input  logic [CODE_WIDTH-1:0]    load_code,
  input  logic                     load_enable,
  input  logic                     load_blink,
  output logic                     load_error,
  output logic [TOTAL_COLUMNS-1:0] column_select,
  output logic [COLUMN_SIZE-1:0]   row_data,
  output logic                     frame_tick
);

  localparam int DIV_W = idx_w(SCAN_DIV);
  localparam int BLK_W = idx_w(BLINK_FRAMES);

  column_t cols [TOTAL_COLUMNS];

  logic [DIV_W-1:0] divider, div_next;
  logic [IDX_W-1:0] scan_idx, idx_next;
  logic [BLK_W-1:0] blink_cnt, blink_cnt_next;
  logic             blink_phase, phase_next;
  logic             div_last, frame_wrap;
  logic             accept, idx_ok;
  column_t          wr_rec, shown;
  logic [COLUMN_SIZE-1:0] shown_pattern;

  // Next scan position and blink state; outputs are built from these so they line up with the state.
  always_comb begin
    div_last       = (divider == DIV_W'(SCAN_DIV - 1));
    frame_wrap     = div_last && (scan_idx == IDX_W'(TOTAL_COLUMNS - 1));
    div_next       = div_last ? '0 : divider + DIV_W'(1);
    idx_next       = scan_idx;
    blink_cnt_next = blink_cnt;
    phase_next     = blink_phase;
    if (div_last) begin
      idx_next = frame_wrap ? '0 : scan_idx + IDX_W'(1);
    end
    if (frame_wrap) begin
      if (blink_cnt == BLK_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_next = '0;
        phase_next     = ~blink_phase;
      end else begin
        blink_cnt_next = blink_cnt + BLK_W'(1);
      end
    end
  end

  // Write decode plus bypass so a write to the column about to be shown is seen without an extra cycle.
  always_comb begin
    accept = load_valid && load_ready;
    idx_ok = (int'(load_index) < TOTAL_COLUMNS);
    wr_rec = '{code: load_code, enable: load_enable, blink: load_blink};
    shown  = cols[idx_next];
    if (accept && idx_ok && (load_index == idx_next)) begin
      shown = wr_rec;
    end
  end

  column_pattern_rom #(
    .COLUMN_SIZE (COLUMN_SIZE),
    .CODE_WIDTH  (CODE_WIDTH)
  ) u_rom (
    .code    (shown.code),
    .pattern (shown_pattern)
  );

  // State and registered outputs; divider position 0 of every slot is a blanking cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < TOTAL_COLUMNS; i++) begin
        cols[i] <= '0;
      end
      divider       <= '0;
      scan_idx      <= '0;
      blink_cnt     <= '0;
      blink_phase   <= 1'b0;
      load_ready    <= 1'b0;
      load_error    <= 1'b0;
      frame_tick    <= 1'b0;
      column_select <= '1;
      row_data      <= '0;
    end else begin
      if (accept && idx_ok) begin
        cols[load_index] <= wr_rec;
      end
      divider     <= div_next;
      scan_idx    <= idx_next;
      blink_cnt   <= blink_cnt_next;
      blink_phase <= phase_next;
      load_ready  <= 1'b1;
      load_error  <= accept && !idx_ok;
      frame_tick  <= frame_wrap;
      if (div_next == '0) begin
        column_select <= '1;
        row_data      <= '0;
      end else begin
        column_select <= ~(TOTAL_COLUMNS'(1) << idx_next);
        row_data      <= (shown.enable && !(shown.blink && phase_next)) ? shown_pattern : '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_display_scanner.sv
// Self-checking bench for matrix_display_scanner with a small scan (5 columns, 4 cycles/slot, 2-frame blink).
// Reference model derives every output from the count of clock edges since reset plus a table of stored columns.
// Directed scenarios followed by a randomized write stream.
module tb_matrix_display_scanner;

  localparam int CS = 7;
  localparam int TC = 5;
  localparam int CW = 3;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          load_valid = 1'b0;
  logic [IW-1:0] load_index = '0;
  logic [CW-1:0] load_code = '0;
  logic          load_enable = 1'b0;
  logic          load_blink = 1'b0;
  logic          load_ready, load_error, frame_tick;
  logic [TC-1:0] column_select;
  logic [CS-1:0] row_data;

  int checks = 0;
  int passed = 0;

  // Reference glyph table, independent of the design's copy.
  logic [CS-1:0] glyph [8] = '{7'h00, 7'h7F, 7'h41, 7'h2A, 7'h1C, 7'h55, 7'h63, 7'h08};

  // Model state: edges since reset release, stored columns, expected error pulse.
  int            n = 0;
  logic [CW-1:0] m_code [TC];
  bit            m_en [TC];
  bit            m_bl [TC];
  bit            m_err = 1'b0;

  matrix_display_scanner #(
    .COLUMN_SIZE   (CS),
    .TOTAL_COLUMNS (TC),
    .CODE_WIDTH    (CW),
    .SCAN_DIV      (SD),
    .BLINK_FRAMES  (BF)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_index    (load_index),
    .load_code     (load_code),
    .load_enable   (load_enable),
    .load_blink    (load_blink),
    .load_error    (load_error),
    .column_select (column_select),
    .row_data      (row_data),
    .frame_tick    (frame_tick)
  );

  always #5 clk = ~clk;

  function automatic logic [TC-1:0] exp_cs();
    if (n % SD == 0) return '1;
    return ~(TC'(1) << ((n / SD) % TC));
  endfunction

  function automatic logic [CS-1:0] exp_row();
    logic [2:0] ci;
    int         phase;
    if (n % SD == 0) return '0;
    ci    = 3'((n / SD) % TC);
    phase = ((n / (SD * TC)) / BF) % 2;
    if (!m_en[ci] || (m_bl[ci] && phase == 1)) return '0;
    return glyph[m_code[ci]];
  endfunction

  function automatic logic exp_ft();
    return (n > 0) && (n % (SD * TC) == 0);
  endfunction

  function automatic logic exp_ready();
    return (n >= 1);
  endfunction

  // Advance one clock edge and update the model with what the design should have done at it.
  task automatic tick();
    bit acc;
    acc = load_valid && (n >= 1);
    @(posedge clk);
    if (!reset_n) begin
      n     = 0;
      m_err = 1'b0;
      for (int i = 0; i < TC; i++) begin
        m_code[i] = '0;
        m_en[i]   = 1'b0;
        m_bl[i]   = 1'b0;
      end
    end else begin
      m_err = acc && (load_index >= TC);
      if (acc && load_index < TC) begin
        m_code[load_index] = load_code;
        m_en[load_index]   = load_enable;
        m_bl[load_index]   = load_blink;
      end
      n++;
    end
    #1;
  endtask

  task automatic set_write(input int idx, input int code, input bit en, input bit bl);
    load_valid  = 1'b1;
    load_index  = IW'(idx);
    load_code   = CW'(code);
    load_enable = en;
    load_blink  = bl;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (column_select !== 5'b11111) $display("FAIL reset_cs got %b want 11111", column_select); else passed++;
      checks++; if (row_data !== 7'h00) $display("FAIL reset_row got %h want 00", row_data); else passed++;
      checks++; if (load_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", load_ready); else passed++;
      checks++; if (load_error !== 1'b0 || frame_tick !== 1'b0) $display("FAIL reset_pulses got err=%b ft=%b want 0 0", load_error, frame_tick); else passed++;
    end
    reset_n = 1'b1;
    checks++; if (load_ready !== 1'b0) $display("FAIL release_ready_early got %b want 0", load_ready); else passed++;
    tick();
    checks++; if (load_ready !== 1'b1) $display("FAIL release_ready got %b want 1", load_ready); else passed++;
    checks++; if (column_select !== exp_cs()) $display("FAIL release_cs got %b want %b", column_select, exp_cs()); else passed++;
  endtask

  task automatic test_scan();
    int ticks_seen;
    ticks_seen = 0;
    set_write(2, 5, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (frame_tick === 1'b1) ticks_seen++;
      checks++; if (column_select !== exp_cs()) $display("FAIL scan_cs n=%0d got %b want %b", n, column_select, exp_cs()); else passed++;
      checks++; if (row_data !== exp_row()) $display("FAIL scan_row n=%0d got %h want %h", n, row_data, exp_row()); else passed++;
      checks++; if (frame_tick !== exp_ft()) $display("FAIL scan_ft n=%0d got %b want %b", n, frame_tick, exp_ft()); else passed++;
      if (n % (SD * TC) == 10) begin
        checks++; if (row_data !== 7'h55 || column_select !== 5'b11011) $display("FAIL scan_col2 got cs=%b row=%h want 11011 55", column_select, row_data); else passed++;
      end
    end
    checks++; if (ticks_seen != 2) $display("FAIL scan_frame_count got %0d want 2", ticks_seen); else passed++;
  endtask

  task automatic test_bad_index();
    set_write(7, 7, 1'b1, 1'b1);
    tick();
    load_valid = 1'b0;
    checks++; if (load_error !== 1'b1) $display("FAIL bad_idx_err got %b want 1", load_error); else passed++;
    tick();
    checks++; if (load_error !== 1'b0) $display("FAIL bad_idx_err_clear got %b want 0", load_error); else passed++;
    for (int i = 0; i < SD * TC; i++) begin
      tick();
      checks++; if (row_data !== exp_row() || column_select !== exp_cs()) $display("FAIL bad_idx_scan n=%0d got cs=%b row=%h want %b %h", n, column_select, row_data, exp_cs(), exp_row()); else passed++;
    end
  endtask

  task automatic test_blink();
    do_reset();
    set_write(0, 3, 1'b1, 1'b1);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 5 * SD * TC; i++) begin
      tick();
      checks++; if (row_data !== exp_row() || column_select !== exp_cs()) $display("FAIL blink n=%0d got cs=%b row=%h want %b %h", n, column_select, row_data, exp_cs(), exp_row()); else passed++;
      if (n % (SD * TC) == 2 && n > SD * TC) begin
        checks++; if (row_data !== (((n / (SD * TC)) / 2) % 2 == 1 ? 7'h00 : 7'h2A)) $display("FAIL blink_frame n=%0d got %h", n, row_data); else passed++;
      end
    end
  endtask

  task automatic test_midslot_rewrite();
    set_write(1, 2, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < SD * TC && n % (SD * TC) != 6; i++) tick();
    checks++; if (n % (SD * TC) != 6) $display("FAIL rewrite_reach got n=%0d want slot offset 6", n); else passed++;
    checks++; if (row_data !== 7'h41 || column_select !== 5'b11101) $display("FAIL rewrite_before got cs=%b row=%h want 11101 41", column_select, row_data); else passed++;
    set_write(1, 6, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    checks++; if (row_data !== 7'h63 || column_select !== 5'b11101) $display("FAIL rewrite_after got cs=%b row=%h want 11101 63", column_select, row_data); else passed++;
  endtask

  task automatic test_reset_midscan();
    set_write(2, 5, 1'b1, 1'b0);
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < SD * TC && n % (SD * TC) != 13; i++) tick();
    checks++; if (column_select !== 5'b10111) $display("FAIL midreset_slot got %b want 10111", column_select); else passed++;
    reset_n = 1'b0;
    tick();
    checks++; if (column_select !== 5'b11111 || row_data !== 7'h00) $display("FAIL midreset_out got cs=%b row=%h want 11111 00", column_select, row_data); else passed++;
    checks++; if (load_ready !== 1'b0 || load_error !== 1'b0 || frame_tick !== 1'b0) $display("FAIL midreset_ctl got rdy=%b err=%b ft=%b want 0 0 0", load_ready, load_error, frame_tick); else passed++;
    reset_n = 1'b1;
    tick();
    checks++; if (column_select !== 5'b11110) $display("FAIL midreset_restart got %b want 11110", column_select); else passed++;
    for (int i = 0; i < SD * TC; i++) begin
      tick();
      checks++; if (row_data !== exp_row()) $display("FAIL midreset_scan n=%0d got %h want %h", n, row_data, exp_row()); else passed++;
      if (n % (SD * TC) == 10) begin
        checks++; if (row_data !== 7'h00) $display("FAIL midreset_col2_cleared got %h want 00", row_data); else passed++;
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      load_valid  = ($urandom_range(0, 1) == 1);
      load_index  = IW'($urandom_range(0, 7));
      load_code   = CW'($urandom_range(0, 7));
      load_enable = ($urandom_range(0, 3) != 0);
      load_blink  = ($urandom_range(0, 1) == 1);
      tick();
      checks++; if (column_select !== exp_cs()) $display("FAIL rand_cs n=%0d got %b want %b", n, column_select, exp_cs()); else passed++;
      checks++; if (row_data !== exp_row()) $display("FAIL rand_row n=%0d got %h want %h", n, row_data, exp_row()); else passed++;
      checks++; if (load_error !== m_err) $display("FAIL rand_err n=%0d got %b want %b", n, load_error, m_err); else passed++;
      checks++; if (frame_tick !== exp_ft() || load_ready !== exp_ready()) $display("FAIL rand_ctl n=%0d got ft=%b rdy=%b want %b %b", n, frame_tick, load_ready, exp_ft(), exp_ready()); else passed++;
    end
    load_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_bad_index();
    test_blink();
    test_midslot_rewrite();
    test_reset_midscan();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/matrix_display_scanner.md
Name: matrix_display_scanner

Overview:
Time-multiplexed driver for the dot-matrix game display. It is the parametrised successor to the static per-column decoder. It stores one symbol code per column, written through a valid/ready port, and decodes each code to a COLUMN_SIZE-bit pattern. It scans one column at a time with inter-column blanking and supports per-column blinking, driving the physical column-select and row lines directly.

Parameters:
COLUMN_SIZE, 7, rows per column (pattern width)
TOTAL_COLUMNS, 5, number of columns scanned (>=2)
CODE_WIDTH, 3, symbol code width (2**CODE_WIDTH patterns)
SCAN_DIV, 50000, clk cycles each column is driven (>=2)
BLINK_FRAMES, 32, full frames per blink half-period (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
load_valid  in  1  column write request
load_ready  out  1  write can be accepted
load_index  in  IDX_W=$clog2(TOTAL_COLUMNS)  target column
load_code  in  CODE_WIDTH  symbol code
load_enable  in  1  column lit when 1, dark when 0
load_blink  in  1  column blinks when 1
load_error  out  1  one-cycle pulse: accepted write had index >= TOTAL_COLUMNS
column_select  out  TOTAL_COLUMNS  active-low one-hot column drive
row_data  out  COLUMN_SIZE  active-high row pattern for the selected column
frame_tick  out  1  one-cycle pulse when the scan wraps to column 0

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on the rising edge of clk).
- Reset values:
  - all column registers have code=0, enable=0, blink=0
  - scan index=0, divider=0, blink counter=0, blink phase=0
  - column_select=all 1s, row_data=0, load_ready=0, load_error=0, frame_tick=0
- load_ready rises the first cycle after reset_n deasserts and stays 1 thereafter.
- Write handshake:
  - A write is accepted on a cycle with load_valid&&load_ready.
  - Valid index: the column register updates at that edge.
  - Invalid index: no register changes; load_error=1 the next cycle.
  - load_valid held high writes every cycle.
- Divider counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and the scan index advances, wrapping from TOTAL_COLUMNS-1 to 0.
- Output sequencing (all outputs registered), per column slot:
  - cycle 0 (divider=0): blanking; column_select=all 1s, row_data=0.
  - cycles 1..SCAN_DIV-1: column_select bit[index]=0, others 1.
- row_data during the drive cycles:
  - 0 if the column is disabled, or if blink=1 and blink phase=1.
  - Otherwise PATTERN[code].
- row_data is recomputed every cycle, so a write to the displayed column is visible one cycle after acceptance.
- frame_tick=1 for exactly the cycle in which the index changes from TOTAL_COLUMNS-1 to 0.
- Blink counter counts frame_ticks 0..BLINK_FRAMES-1. On wrap, blink phase toggles, so the blink period is 2*BLINK_FRAMES frames.
- A simultaneous write and scan advance are both honoured; neither delays the other.
- Reset mid-scan returns all state to reset values at that edge; stored codes are lost.

Decomposition:
- Package matrix_display_pkg:
  - PATTERN constant array, 2**CODE_WIDTH entries of COLUMN_SIZE bits
  - column-record typedef {code, enable, blink}
  - IDX_W function
- Sub-module column_pattern_rom: combinational code -> pattern lookup from PATTERN. It is instantiated once, on the currently scanned column.

Test Plan:
Bench parameters: TOTAL_COLUMNS=5, SCAN_DIV=4, BLINK_FRAMES=2.
1. Hold reset_n=0 for 3 cycles, then release -> column_select=5'b11111, row_data=0, load_ready=0 during reset; load_ready=1 one cycle after release.
2. Write idx 2, code 5, enable 1, blink 0; let the scan run -> row_data=PATTERN[5] with column_select=5'b11011 for 3 cycles, preceded by 1 blank cycle; other columns dark; frame_tick every 20 cycles.
3. Write idx 7 -> load_error pulses 1 cycle; all columns unchanged.
4. Column 0 with enable=1, blink=1, code 3 -> PATTERN[3] for frames 0-1, 0 for frames 2-3, PATTERN[3] again from frame 4.
5. Rewrite column 1 to code 6 in the middle of its slot -> row_data changes to PATTERN[6] one cycle after acceptance, with column_select unchanged.
6. Assert reset_n=0 during column 3's slot -> next cycle all outputs are at reset values and column 2's code is cleared; scan restarts at column 0.
